// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan driver.
// Contents:
//   seg7_state_e : scan FSM state (all-off gap, digit lit)
//   seg7_word_t  : buffered display word (decimal points + hex nibbles)
//   SEG_OFF      : segment pattern with every segment dark (active-low)
//   AN_OFF       : anode pattern with every digit dark (active-low)
//   hex_seg()    : hex nibble -> {g,f,e,d,c,b,a} active-low segment pattern
package seg7_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } seg7_state_e;

  typedef struct packed {
    logic [3:0]  dp;    // decimal point per digit, active-high
    logic [15:0] data;  // digit k is data[4k+3:4k], digit 0 rightmost
  } seg7_word_t;

  localparam logic [6:0] SEG_OFF = 7'b111_1111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_OFF;
    case (nib)
      4'h0: s = 7'b100_0000;
      4'h1: s = 7'b111_1001;
      4'h2: s = 7'b010_0100;
      4'h3: s = 7'b011_0000;
      4'h4: s = 7'b001_1001;
      4'h5: s = 7'b001_0010;
      4'h6: s = 7'b000_0010;
      4'h7: s = 7'b111_1000;
      4'h8: s = 7'b000_0000;
      4'h9: s = 7'b001_0000;
      4'hA: s = 7'b000_1000;
      4'hB: s = 7'b000_0011;
      4'hC: s = 7'b100_0110;
      4'hD: s = 7'b010_0001;
      4'hE: s = 7'b000_0110;
      4'hF: s = 7'b000_1110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Purely combinational hex-digit decoder.
// Ports:
//   nib_i : 4-bit hex nibble
//   seg_o : {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_seg(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit is preceded by BLANK_CYC all-off cycles and lit for ON_CYC
// cycles. The shown word is double-buffered and only replaced at the frame
// boundary (last lit cycle of digit 3) so a frame never mixes two words.
// Ports:
//   clk         : clock
//   rst_n       : synchronous reset, active-HIGH despite the name
//   data_in     : word to display, digit k = data_in[4k+3:4k]
//   data_valid  : one-cycle strobe capturing data_in / dp_in
//   dp_in       : per-digit decimal points, active-high
//   blank_lz    : leading-zero blanking enable (level)
//   seg         : {g,f,e,d,c,b,a}, active-low, registered
//   dp          : decimal point, active-low, registered
//   an          : anodes, active-low, registered
//   frame_tick  : one-cycle pulse when the new word is first held
//   dbg_state_o : current scan FSM state
//
// Handshake: data_valid is a fire-and-forget strobe with no ready; every
// strobe is accepted and the most recent one before a commit is displayed.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int ON_CYC    = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick,
  output seg7_state_e dbg_state_o
);

  localparam int MAXC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  seg7_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  seg7_word_t    pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  seg7_word_t    disp_q, disp_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          tick_q;
  logic          commit;

  logic [3:0]    nib;
  logic [6:0]    seg_raw;
  logic [3:0]    hi_zero;
  logic          digit_blank;

  // Scan FSM: commit happens on the ON->BLANK transition out of digit 3.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    commit  = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          commit  = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Double buffer. A strobe landing on the commit cycle bypasses the pending
  // register so it is not delayed by a whole frame.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    if (commit) begin
      pend_vld_d = 1'b0;
      if (data_valid) begin
        disp_d = '{dp: dp_in, data: data_in};
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
    end else if (data_valid) begin
      pend_d     = '{dp: dp_in, data: data_in};
      pend_vld_d = 1'b1;
    end
  end

  assign nib = 4'(disp_q.data >> {idx_q, 2'b00});

  hex_to_seg7 u_hex_to_seg7 (
    .nib_i (nib),
    .seg_o (seg_raw)
  );

  // hi_zero[k]: nibble k and every nibble above it are zero.
  always_comb begin
    hi_zero[3] = (disp_q.data[15:12] == 4'h0);
    hi_zero[2] = hi_zero[3] && (disp_q.data[11:8] == 4'h0);
    hi_zero[1] = hi_zero[2] && (disp_q.data[7:4] == 4'h0);
    hi_zero[0] = 1'b0;
  end

  assign digit_blank = blank_lz && hi_zero[idx_q];

  // Output pattern is latched on the first ON cycle and held for the rest of
  // the digit, so blank_lz only matters at ON entry.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == ST_ON) begin
      if (cnt_q == '0) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = digit_blank ? SEG_OFF : seg_raw;
        dp_d  = ~disp_q.dp[idx_q];
      end else begin
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= AN_OFF;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      tick_q     <= commit;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_tick  = tick_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream display stage for the processor top: consumes the 16-bit result word and drives a 4-digit common-anode seven-segment display. Time-multiplexes the digits with a programmable on-time and an anti-ghosting blank gap. The word is double-buffered so the display changes only at frame boundaries, which prevents tearing. Optional leading-zero blanking and per-digit decimal points are supported.

## Interface
- ON_CYC, default 1000: cycles each digit is lit per frame, ≥1.
- BLANK_CYC, default 4: cycles with all anodes off before each digit, ≥1.
- clk, input, 1: sole clock.
- rst_n, input, 1: reset; synchronous, active-high (1 = reset). The name is kept for consistency with the processor top.
- data_in, input, 16: word to display. Digit k shows data_in[4k+3:4k]; digit 0 is the rightmost.
- data_valid, input, 1: single-cycle strobe that captures data_in and dp_in.
- dp_in, input, 4: decimal point per digit, active-high, captured with data_in.
- blank_lz, input, 1: level signal; 1 enables leading-zero blanking and is sampled live.
- seg, output, 7: {g,f,e,d,c,b,a}, active-low, registered.
- dp, output, 1: decimal point, active-low, registered.
- an, output, 4: anodes, active-low, one-hot-low or all 1, registered.
- frame_tick, output, 1: one-cycle pulse in the cycle the display register commits.

## Operation
- Registers:
  - pending_reg (16+4 bits), pending flag.
  - disp_reg (16+4 bits).
  - idx (2 bits).
  - cnt (sized for max(ON_CYC, BLANK_CYC)).
  - state ∈ {BLANK, ON}.
- data_valid=1 loads pending_reg and sets pending. A later strobe overwrites pending_reg; the last strobe before a commit wins.
- FSM:
  - BLANK: all outputs off. After BLANK_CYC cycles, go to ON.
  - ON: an[idx]=0, and seg/dp show disp_reg digit idx. After ON_CYC cycles, go to BLANK and set idx←idx+1 (wraps 3→0).
- Commit:
  - Occurs in the last ON cycle of idx=3.
  - If data_valid=1 in that cycle, disp_reg←data_in/dp_in directly (bypass).
  - Otherwise, if pending=1, disp_reg←pending_reg.
  - pending clears in either case. frame_tick pulses every frame, whether or not the value changed.
- Decode: hex 0–F uses the standard shapes (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, … F=0001110).
- Leading-zero blanking: with blank_lz=1, digit k∈{3,2,1} is blanked (seg=1111111, dp still honoured) when its nibble and all higher nibbles are zero. Digit 0 is never blanked.
- Off state: an=1111, seg=1111111, dp=1.

## Timing
- Reset values:
  - an=1111, seg=1111111, dp=1, frame_tick=0.
  - state=BLANK, idx=0, cnt=0.
  - disp_reg=0, pending_reg=0, pending=0.
- Frame period is 4·(BLANK_CYC+ON_CYC) cycles. With ON_CYC=8 and BLANK_CYC=2 it is 40.
- Outputs are registered with one cycle of latency from the state:
  - The first cycle with an=1110 is BLANK_CYC+1 cycles after the first clock edge with rst_n=0.
  - an stays 1110 for exactly ON_CYC cycles.
- Only one anode is ever low. There is at least one all-off cycle between any two lit digits.
- A capture reaches the display at the next commit. Worst-case latency is one frame plus one cycle.
- Reset asserted mid-frame (including mid-commit) forces the reset values on the next edge. The pending value is discarded.
- blank_lz changes take effect at the next ON entry; the displayed value itself changes only at a commit.

## Structure
- seg7_pkg holds:
  - The state enum.
  - The SEG_OFF/AN_OFF constants.
  - The 16-entry hex→segment table as a constant function.
- A single sub-module, hex_to_seg7 (4-bit nibble in, 7-bit active-low segments out), is purely combinational and instantiated once on the muxed nibble.
- seg7_scan_driver owns the FSM, counters, buffers and leading-zero logic.

## Test plan
- Reset: hold rst_n=1 for 3 cycles → an=1111, seg=1111111, dp=1, frame_tick=0. Release → first an=1110 appears BLANK_CYC+1 cycles later.
- Scan order (ON_CYC=8, BLANK_CYC=2):
  - an sequences 1110,1111×2,1101,1111×2,1011,1111×2,0111, each lit for 8 cycles.
  - frame_tick pulses every 40 cycles.
  - an is never two-low.
- Value decode: strobe 16'h1234 with dp_in=0001 → after the next frame_tick:
  - an=1110: seg=0011001, dp=0.
  - an=1101: seg=0110000.
  - an=1011: seg=0100100.
  - an=0111: seg=1111001.
  - dp=1 on digits 1–3.
- Deferred update and coincidence:
  - Strobe 16'hAAAA mid-frame → all digits stay at the old value until frame_tick.
  - A strobe of 16'h5555 exactly in the commit cycle → 16'h5555 is shown; pending=0 afterwards.
- Leading-zero blanking: 16'h0005 with blank_lz=1 → digits 3–1 show 1111111 and digit 0 shows 0010010. With 16'h0000, digit 0 shows 1000000.
- Reset mid-scan: assert rst_n=1 while an=1011 with a pending strobe → next edge gives reset values. After release, the display shows 0000 and the pending value never appears.
